hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL: i_clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-002 SHALL: i_rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL: i_addr_rsD / i_addr_rtD  in  5 each  rs/rt fields of instruction in decode.
REQ-004 SHALL: i_con_usersD / i_con_usertD  in  1 each  decode instruction reads rs/rt.
REQ-005 SHALL: i_addr_rtE  in  5  rt of instruction in execute; i_con_memreadE  in  1  execute instruction is a load.
REQ-006 SHALL: i_con_jumpD  in  2  jump select from decode; nonzero = jump taken.
REQ-007 SHALL: i_con_branchE  in  1  branch resolved taken in execute.
REQ-008 SHALL: i_con_mdstartD  in  1  mult/div issued in decode; i_con_mddivD  in  1  1=div, 0=mult.
REQ-009 SHALL: i_con_hiloreadD  in  1  decode instruction reads HI/LO (mfhi/mflo).
REQ-010 SHALL: o_con_stallF / o_con_stallD  out  1 each  hold PC / hold IF-ID register.
REQ-011 SHALL: o_con_flushD / o_con_flushE  out  1 each  clear IF-ID / ID-EX register (bubble).
REQ-012 SHALL: o_con_mdbusy  out  1  mult/div unit busy; o_con_mddone  out  1  one-cycle completion pulse.
REQ-013 SHALL: o_data_mdcnt  out  6  remaining mult/div cycles; o_data_stallcnt  out  16  total stall cycles, saturating.

Function
REQ-014 SHALL: load-use hazard (lu) = i_con_memreadE & (i_addr_rtE!=0) & ((rtE==rsD & usersD) | (rtE==rtD & usertD)).
REQ-015 SHALL: FSM states IDLE, MDBUSY; state held in a register, combinational outputs derived from state and inputs same cycle.
REQ-016 SHALL: md hazard (mh) = state==MDBUSY & (i_con_hiloreadD | i_con_mdstartD).
REQ-017 SHALL: priority, highest first: branchE, lu, mh, jumpD.
REQ-018 SHALL: branchE=1 -> flushD=1, flushE=1, stallF=stallD=0, regardless of other inputs.
REQ-019 SHALL: else lu|mh -> stallF=stallD=1, flushE=1, flushD=0.
REQ-020 SHALL: else jumpD!=0 -> flushD=1, others 0; otherwise all four 0.
REQ-021 SHALL: IDLE -> MDBUSY when mdstartD=1, branchE=0, lu=0; mdcnt loads 32 (div) or 4 (mult).
REQ-022 SHALL: MDBUSY: mdcnt decrements by 1 each cycle; when mdcnt==1, next cycle state=IDLE, mdcnt=0, mddone=1 for exactly that one cycle.
REQ-023 SHALL: mdstartD arriving in MDBUSY is stalled (REQ-016) and starts in the cycle after return to IDLE if still presented and not otherwise blocked; no back-to-back overlap.
REQ-024 SHALL: branchE does not abort an operation already in MDBUSY; only suppresses a new start.
REQ-025 SHALL: o_con_mdbusy = (state==MDBUSY).
REQ-026 SHALL: stallcnt increments by 1 each cycle stallD=1; holds at 16'hFFFF.
REQ-027 SHALL: register 0 never creates a load-use hazard; hiloreadD in IDLE creates no stall.

Reset
REQ-028 SHALL: i_rst=1 asynchronously forces state=IDLE, mdcnt=0, mddone=0, stallcnt=0.
REQ-029 SHALL: reset during MDBUSY aborts the operation with no mddone pulse; after release, with all inputs 0, all outputs are 0.

Verification
REQ-030 SHALL: memreadE=1, rtE=5, rsD=5, usersD=1 -> stallF=stallD=flushE=1 same cycle, stallcnt +1; rtE=0 -> no stall.
REQ-031 SHALL: mdstartD=1, mddivD=0 in IDLE -> mdbusy=1 for 4 cycles, mdcnt 4,3,2,1, mddone pulses once on the following cycle with mdcnt=0.
REQ-032 SHALL: div started, hiloreadD=1 held -> stallD=1 for all 32 busy cycles, released the cycle mddone=1; stallcnt=32.
REQ-033 SHALL: branchE=1 with lu=1 and jumpD=2 -> flushD=flushE=1, stallF=stallD=0.
REQ-034 SHALL: i_rst pulsed at mdcnt=17 of a div -> immediate IDLE, mdcnt=0, no mddone pulse.
REQ-035 SHALL: stallcnt preloaded near 16'hFFFF by 70000 forced stall cycles -> reads 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller with mult/div busy tracking
//
// Purpose: detects load-use and HI/LO-vs-mult/div hazards in decode, resolves
// them against taken branches and jumps, tracks the multi-cycle mult/div unit,
// and keeps a saturating count of decode stall cycles.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_addr_rsD/i_addr_rtD     decode source register fields
//   i_con_usersD/usertD       decode instruction actually reads rs / rt
//   i_addr_rtE, i_con_memreadE  execute destination (rt) and load flag
//   i_con_jumpD               decode jump select, nonzero = taken
//   i_con_branchE             branch resolved taken in execute
//   i_con_mdstartD/mddivD     mult/div issue in decode, 1 = div
//   i_con_hiloreadD           decode reads HI/LO
//   o_con_stallF/stallD       hold PC / IF-ID
//   o_con_flushD/flushE       bubble IF-ID / ID-EX
//   o_con_mdbusy/mddone       mult/div busy, one-cycle completion pulse
//   o_data_mdcnt              remaining mult/div cycles
//   o_data_stallcnt           saturating count of stallD cycles

module hazard_ctrl (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [4:0]  i_addr_rsD,
   input  logic [4:0]  i_addr_rtD,
   input  logic        i_con_usersD,
   input  logic        i_con_usertD,
   input  logic [4:0]  i_addr_rtE,
   input  logic        i_con_memreadE,
   input  logic [1:0]  i_con_jumpD,
   input  logic        i_con_branchE,
   input  logic        i_con_mdstartD,
   input  logic        i_con_mddivD,
   input  logic        i_con_hiloreadD,
   output logic        o_con_stallF,
   output logic        o_con_stallD,
   output logic        o_con_flushD,
   output logic        o_con_flushE,
   output logic        o_con_mdbusy,
   output logic        o_con_mddone,
   output logic [5:0]  o_data_mdcnt,
   output logic [15:0] o_data_stallcnt
);

   typedef enum logic {IDLE = 1'b0, MDBUSY = 1'b1} state_t;

   state_t      state_q;
   logic [5:0]  mdcnt_q;
   logic        mddone_q;
   logic [15:0] stallcnt_q;
   logic [15:0] stallcnt_d;

   logic lu;
   logic mh;

   // r0 is hardwired zero, so a load targeting it never produces a dependency.
   assign lu = i_con_memreadE && (i_addr_rtE != 5'd0) &&
               (((i_addr_rtE == i_addr_rsD) && i_con_usersD) ||
                ((i_addr_rtE == i_addr_rtD) && i_con_usertD));

   // While the unit is busy, HI/LO readers and new mult/div issues must wait.
   assign mh = (state_q == MDBUSY) && (i_con_hiloreadD || i_con_mdstartD);

   always_comb begin
      o_con_stallF = 1'b0;
      o_con_stallD = 1'b0;
      o_con_flushD = 1'b0;
      o_con_flushE = 1'b0;
      if (i_con_branchE) begin
         o_con_flushD = 1'b1;
         o_con_flushE = 1'b1;
      end else if (lu || mh) begin
         o_con_stallF = 1'b1;
         o_con_stallD = 1'b1;
         o_con_flushE = 1'b1;
      end else if (i_con_jumpD != 2'd0) begin
         o_con_flushD = 1'b1;
      end
   end

   always_comb begin
      stallcnt_d = stallcnt_q;
      if (o_con_stallD && (stallcnt_q != 16'hFFFF)) begin
         stallcnt_d = stallcnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         mdcnt_q    <= 6'd0;
         mddone_q   <= 1'b0;
         stallcnt_q <= 16'd0;
      end else begin
         stallcnt_q <= stallcnt_d;
         case (state_q)
            IDLE: begin
               mddone_q <= 1'b0;
               // A taken branch squashes the issuing instruction; a load-use
               // stall means it has not really issued yet.
               if (i_con_mdstartD && !i_con_branchE && !lu) begin
                  state_q <= MDBUSY;
                  mdcnt_q <= i_con_mddivD ? 6'd32 : 6'd4;
               end
            end
            MDBUSY: begin
               if (mdcnt_q == 6'd1) begin
                  state_q  <= IDLE;
                  mdcnt_q  <= 6'd0;
                  mddone_q <= 1'b1;
               end else begin
                  mdcnt_q  <= mdcnt_q - 6'd1;
                  mddone_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= IDLE;
               mdcnt_q  <= 6'd0;
               mddone_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_con_mdbusy    = (state_q == MDBUSY);
   assign o_con_mddone    = mddone_q;
   assign o_data_mdcnt    = mdcnt_q;
   assign o_data_stallcnt = stallcnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rsD, rtD, rtE;
   logic        usersD, usertD, memE, branchE, mdstart, mddiv, hiloread;
   logic [1:0]  jumpD;
   logic        stallF, stallD, flushD, flushE, mdbusy, mddone;
   logic [5:0]  mdcnt;
   logic [15:0] stallcnt;

   int errors = 0;
   int checks = 0;

   // reference model state
   bit m_busy;
   int m_left;
   bit m_done;
   int m_stalls;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .i_clk(clk), .i_rst(rst),
      .i_addr_rsD(rsD), .i_addr_rtD(rtD),
      .i_con_usersD(usersD), .i_con_usertD(usertD),
      .i_addr_rtE(rtE), .i_con_memreadE(memE),
      .i_con_jumpD(jumpD), .i_con_branchE(branchE),
      .i_con_mdstartD(mdstart), .i_con_mddivD(mddiv),
      .i_con_hiloreadD(hiloread),
      .o_con_stallF(stallF), .o_con_stallD(stallD),
      .o_con_flushD(flushD), .o_con_flushE(flushE),
      .o_con_mdbusy(mdbusy), .o_con_mddone(mddone),
      .o_data_mdcnt(mdcnt), .o_data_stallcnt(stallcnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      rsD = 0; rtD = 0; rtE = 0; usersD = 0; usertD = 0; memE = 0;
      branchE = 0; mdstart = 0; mddiv = 0; hiloread = 0; jumpD = 0;
   endtask

   // Expected pipeline controls from the priority rules applied to current inputs.
   task automatic expect_ctrl(output bit e_sF, output bit e_sD, output bit e_fD,
                              output bit e_fE, output bit e_lu);
      bit dep_rs, dep_rt, mh;
      dep_rs = (rtE == rsD) && usersD;
      dep_rt = (rtE == rtD) && usertD;
      e_lu = memE && (rtE != 0) && (dep_rs || dep_rt);
      mh = m_busy && (hiloread || mdstart);
      e_sF = 0; e_sD = 0; e_fD = 0; e_fE = 0;
      if (branchE) begin
         e_fD = 1; e_fE = 1;
      end else if (e_lu || mh) begin
         e_sF = 1; e_sD = 1; e_fE = 1;
      end else if (jumpD != 0) begin
         e_fD = 1;
      end
   endtask

   // One clock: sample away from the edge, optionally check, then advance the model.
   task automatic step(input bit do_chk);
      bit e_sF, e_sD, e_fD, e_fE, e_lu;
      @(negedge clk);
      #1;
      expect_ctrl(e_sF, e_sD, e_fD, e_fE, e_lu);
      if (do_chk) begin
         chk("stallF", stallF, e_sF);
         chk("stallD", stallD, e_sD);
         chk("flushD", flushD, e_fD);
         chk("flushE", flushE, e_fE);
         chk("mdbusy", mdbusy, m_busy);
         chk("mddone", mddone, m_done);
         chk("mdcnt", mdcnt, m_left);
         chk("stallcnt", stallcnt, m_stalls);
      end
      @(posedge clk);
      if (e_sD) m_stalls = (m_stalls >= 65535) ? 65535 : m_stalls + 1;
      if (!m_busy) begin
         m_done = 0;
         if (mdstart && !branchE && !e_lu) begin
            m_busy = 1;
            m_left = mddiv ? 32 : 4;
         end
      end else begin
         m_left = m_left - 1;
         m_done = (m_left == 0);
         if (m_left == 0) m_busy = 0;
      end
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      #2;
      m_busy = 0; m_left = 0; m_done = 0; m_stalls = 0;
      chk("rst_mdbusy", mdbusy, 0);
      chk("rst_mdcnt", mdcnt, 0);
      chk("rst_mddone", mddone, 0);
      chk("rst_stallcnt", stallcnt, 0);
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   initial begin
      clear_inputs();
      rst = 0;
      #1;
      do_reset();
      step(1);

      // load-use on rs, then the same with r0 as the load target
      memE = 1; rtE = 5; rsD = 5; usersD = 1;
      #1;
      chk("lu_stallF", stallF, 1);
      chk("lu_stallD", stallD, 1);
      chk("lu_flushE", flushE, 1);
      step(1);
      chk("lu_stallcnt", stallcnt, 1);
      rtE = 0; rsD = 0;
      #1;
      chk("r0_stallD", stallD, 0);
      step(1);

      // mult: four busy cycles counting down, then one done pulse
      do_reset();
      mdstart = 1; mddiv = 0;
      step(1);
      mdstart = 0;
      for (int k = 0; k < 4; k++) begin
         chk("mult_busy", mdbusy, 1);
         chk("mult_cnt", mdcnt, 4 - k);
         chk("mult_done_low", mddone, 0);
         step(1);
      end
      chk("mult_done", mddone, 1);
      chk("mult_cnt_end", mdcnt, 0);
      chk("mult_idle", mdbusy, 0);
      step(1);
      chk("mult_done_once", mddone, 0);

      // div with HI/LO read held through the whole operation
      do_reset();
      mdstart = 1; mddiv = 1; hiloread = 1;
      step(1);
      mdstart = 0;
      for (int k = 0; k < 32; k++) step(1);
      chk("div_done", mddone, 1);
      chk("div_release", stallD, 0);
      chk("div_stallcnt", stallcnt, 32);
      step(1);

      // a taken branch outranks load-use and jump
      do_reset();
      branchE = 1; memE = 1; rtE = 5; rsD = 5; usersD = 1; jumpD = 2;
      #1;
      chk("br_flushD", flushD, 1);
      chk("br_flushE", flushE, 1);
      chk("br_stallF", stallF, 0);
      chk("br_stallD", stallD, 0);
      step(1);

      // reset in the middle of a div aborts it without a done pulse
      do_reset();
      mdstart = 1; mddiv = 1;
      step(1);
      mdstart = 0;
      for (int k = 0; k < 40 && m_left != 17; k++) step(1);
      chk("div_at17", mdcnt, 17);
      do_reset();
      for (int k = 0; k < 20; k++) begin
         step(1);
         chk("abort_no_done", mddone, 0);
      end

      // randomized traffic against the model
      do_reset();
      for (int k = 0; k < 500; k++) begin
         rsD = 5'($urandom_range(0, 3));
         rtD = 5'($urandom_range(0, 3));
         rtE = 5'($urandom_range(0, 3));
         usersD = 1'($urandom);
         usertD = 1'($urandom);
         memE = 1'($urandom);
         branchE = ($urandom_range(0, 7) == 0);
         mdstart = ($urandom_range(0, 3) == 0);
         mddiv = ($urandom_range(0, 3) == 0);
         hiloread = ($urandom_range(0, 2) == 0);
         jumpD = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
         step(1);
      end

      // stall counter saturation
      do_reset();
      memE = 1; rtE = 7; rtD = 7; usertD = 1;
      for (int k = 0; k < 70000; k++) step(0);
      chk("sat_stallcnt", stallcnt, 16'hFFFF);
      step(1);
      chk("sat_hold", stallcnt, 16'hFFFF);

      clear_inputs();
      step(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
